// File: rtl/ascon_pkg.sv
// ascon_pkg: shared state encoding, mode constants and width defaults for the ascon sequencer
package ascon_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_GAP,
    ST_UNLOAD,
    ST_RESP
  } state_t;
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;
  localparam int K_DEF = 128;
  localparam int A_L_DEF = 112;
  localparam int TEXT_L_DEF = 128;
  localparam int NONCE_L = 128;
  localparam int TAG_L = 128;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int ab;
    int cd;
    ab = a > b ? a : b;
    cd = c > d ? c : d;
    return ab > cd ? ab : cd;
  endfunction
endpackage

// File: rtl/ascon_serdes.sv
// ascon_serdes: one operand lane, MSB-first parallel-to-serial toward the core and indexed serial-to-parallel back
module ascon_serdes #(
  parameter int W = 128,
  parameter int N = 128,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [W-1:0]  ld_val,
  input  logic          sh,
  output logic          so,
  input  logic          cap,
  input  logic [IW-1:0] idx,
  input  logic          si,
  output logic [W-1:0]  q
);
  logic [N-1:0] piso_q, piso_d;
  logic [W-1:0] sipo_q, sipo_d;
  always_comb begin
    piso_d = ld ? N'(ld_val) << (N - W) : sh ? piso_q << 1 : piso_q;
    sipo_d = ld ? '0 : cap && 32'(idx) < W ? (sipo_q & ~(W'(1) << idx)) | (W'(si) << idx) : sipo_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      piso_q <= '0;
      sipo_q <= '0;
    end else begin
      piso_q <= piso_d;
      sipo_q <= sipo_d;
    end
  end
  assign so = piso_q[N-1];
  assign q = sipo_q;
endmodule

// File: rtl/ascon_ctrl.sv
// ascon_ctrl: turns one parallel encrypt/decrypt request into the bit-serial ascon core protocol and back
module ascon_ctrl
  import ascon_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int A_L = A_L_DEF,
  parameter int TEXT_L = TEXT_L_DEF,
  parameter int MAX = max4(K, A_L, TEXT_L, TAG_L),
  parameter int START_CYC = 5,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_mode,
  input  logic [K-1:0]       req_key,
  input  logic [NONCE_L-1:0] req_nonce,
  input  logic [A_L-1:0]     req_ad,
  input  logic [TEXT_L-1:0]  req_text,
  input  logic [TAG_L-1:0]   req_tag,
  output logic               core_key_SI,
  output logic               core_nonce_SI,
  output logic               core_ad_SI,
  output logic               core_text_SI,
  output logic               core_tag_SI,
  output logic               core_enc_start,
  output logic               core_dec_start,
  input  logic               core_text_SO,
  input  logic               core_tag_SO,
  input  logic               core_enc_done,
  input  logic               core_dec_done,
  input  logic               core_auth,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [TEXT_L-1:0]  rsp_text,
  output logic [TAG_L-1:0]   rsp_tag,
  output logic               rsp_auth,
  output logic               rsp_err,
  output logic               rsp_mode,
  output logic               busy
);
  localparam int CW = $clog2((MAX > TIMEOUT ? MAX : TIMEOUT) + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mode_q, mode_d, done_seen_q, done_seen_d, auth_q, auth_d, err_q, err_d;
  logic enc_start_q, enc_start_d, dec_start_q, dec_start_d;
  logic [MAX-1:0] key_sr_q, key_sr_d, nonce_sr_q, nonce_sr_d, ad_sr_q, ad_sr_d;
  logic accept, load, unload, done_m;
  assign accept = state_q == ST_IDLE && req_valid;
  assign load = state_q == ST_LOAD;
  assign unload = state_q == ST_UNLOAD;
  assign done_m = mode_q == MODE_DEC ? core_dec_done : core_enc_done;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    mode_d = mode_q;
    done_seen_d = done_seen_q;
    auth_d = auth_q;
    err_d = err_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        state_d = ST_LOAD;
        cnt_d = '0;
        mode_d = req_mode;
        done_seen_d = 1'b0;
        auth_d = 1'b0;
        err_d = 1'b0;
      end
      ST_LOAD: if (cnt_q == CW'(MAX - 1)) begin
        state_d = ST_START;
        cnt_d = '0;
      end
      ST_START: begin
        if (done_m) begin
          done_seen_d = 1'b1;
          auth_d = mode_q == MODE_DEC && core_auth;
        end
        if (cnt_q == CW'(START_CYC - 1)) begin
          state_d = ST_WAIT;
          cnt_d = '0;
        end
      end
      ST_WAIT: if (done_seen_q || done_m) begin
        state_d = ST_GAP;
        cnt_d = '0;
        auth_d = done_m ? mode_q == MODE_DEC && core_auth : auth_q;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = ST_RESP;
        err_d = 1'b1;
      end
      ST_GAP: if (cnt_q == CW'(GAP_CYC - 1)) begin
        state_d = ST_UNLOAD;
        cnt_d = '0;
      end
      ST_UNLOAD: if (cnt_q == CW'(MAX - 1)) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    enc_start_d = state_d == ST_START && mode_d == MODE_ENC;
    dec_start_d = state_d == ST_START && mode_d == MODE_DEC;
    key_sr_d = accept ? MAX'(req_key) << (MAX - K) : load ? key_sr_q << 1 : key_sr_q;
    nonce_sr_d = accept ? MAX'(req_nonce) << (MAX - NONCE_L) : load ? nonce_sr_q << 1 : nonce_sr_q;
    ad_sr_d = accept ? MAX'(req_ad) << (MAX - A_L) : load ? ad_sr_q << 1 : ad_sr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      mode_q <= 1'b0;
      done_seen_q <= 1'b0;
      auth_q <= 1'b0;
      err_q <= 1'b0;
      enc_start_q <= 1'b0;
      dec_start_q <= 1'b0;
      key_sr_q <= '0;
      nonce_sr_q <= '0;
      ad_sr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      done_seen_q <= done_seen_d;
      auth_q <= auth_d;
      err_q <= err_d;
      enc_start_q <= enc_start_d;
      dec_start_q <= dec_start_d;
      key_sr_q <= key_sr_d;
      nonce_sr_q <= nonce_sr_d;
      ad_sr_q <= ad_sr_d;
    end
  end
  ascon_serdes #(.W(TEXT_L), .N(MAX), .IW(CW)) u_text (
    .clk(clk), .rst(rst), .ld(accept), .ld_val(req_text), .sh(load), .so(core_text_SI),
    .cap(unload), .idx(cnt_q), .si(core_text_SO), .q(rsp_text)
  );
  ascon_serdes #(.W(TAG_L), .N(MAX), .IW(CW)) u_tag (
    .clk(clk), .rst(rst), .ld(accept), .ld_val(req_tag), .sh(load), .so(core_tag_SI),
    .cap(unload), .idx(cnt_q), .si(core_tag_SO), .q(rsp_tag)
  );
  assign core_key_SI = key_sr_q[MAX-1];
  assign core_nonce_SI = nonce_sr_q[MAX-1];
  assign core_ad_SI = ad_sr_q[MAX-1];
  assign core_enc_start = enc_start_q;
  assign core_dec_start = dec_start_q;
  assign req_ready = state_q == ST_IDLE;
  assign busy = state_q != ST_IDLE;
  assign rsp_valid = state_q == ST_RESP;
  assign rsp_auth = auth_q;
  assign rsp_err = err_q;
  assign rsp_mode = mode_q;
endmodule

// File: tb/tb_ascon_ctrl.sv
// tb_ascon_ctrl: randomized requests against a behavioural serial core with a spec-level response model
module tb_ascon_ctrl;
  localparam int K = 128, A_L = 112, TEXT_L = 128, MAX = 128;
  localparam int START_CYC = 5, GAP_CYC = 2, TIMEOUT = 4095;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_mode = 1'b0, rsp_ready = 1'b0;
  logic [K-1:0] req_key = '0;
  logic [127:0] req_nonce = '0, req_text = '0, req_tag = '0;
  logic [A_L-1:0] req_ad = '0;
  logic req_ready, busy, rsp_valid, rsp_auth, rsp_err, rsp_mode;
  logic core_key_SI, core_nonce_SI, core_ad_SI, core_text_SI, core_tag_SI;
  logic core_enc_start, core_dec_start, core_text_SO, core_tag_SO;
  logic core_enc_done, core_dec_done, core_auth;
  logic [127:0] rsp_text, rsp_tag;
  int n_cmp = 0, n_bad = 0;
  int t = 0, m_dd = -1, kk, enc_n = 0, dec_n = 0;
  bit running = 1'b0, is_dec = 1'b0, m_auth = 1'b0, so_en;
  logic [127:0] m_text = '0, m_tag = '0;
  logic [MAX-1:0] h_key = '0, h_nonce = '0, h_ad = '0, h_text = '0, h_tag = '0;
  logic [MAX-1:0] s_key = '0, s_nonce = '0, s_ad = '0, s_text = '0, s_tag = '0;

  ascon_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_key(req_key), .req_nonce(req_nonce), .req_ad(req_ad), .req_text(req_text), .req_tag(req_tag),
    .core_key_SI(core_key_SI), .core_nonce_SI(core_nonce_SI), .core_ad_SI(core_ad_SI),
    .core_text_SI(core_text_SI), .core_tag_SI(core_tag_SI),
    .core_enc_start(core_enc_start), .core_dec_start(core_dec_start),
    .core_text_SO(core_text_SO), .core_tag_SO(core_tag_SO),
    .core_enc_done(core_enc_done), .core_dec_done(core_dec_done), .core_auth(core_auth),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_text(rsp_text), .rsp_tag(rsp_tag),
    .rsp_auth(rsp_auth), .rsp_err(rsp_err), .rsp_mode(rsp_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  // core model: keeps the last MAX serial bits per lane and snapshots them when a start strobe first appears
  always @(negedge clk) begin
    if (!busy) begin
      running <= 1'b0;
      enc_n <= 0;
      dec_n <= 0;
      t <= 0;
    end else begin
      h_key <= {h_key[MAX-2:0], core_key_SI};
      h_nonce <= {h_nonce[MAX-2:0], core_nonce_SI};
      h_ad <= {h_ad[MAX-2:0], core_ad_SI};
      h_text <= {h_text[MAX-2:0], core_text_SI};
      h_tag <= {h_tag[MAX-2:0], core_tag_SI};
      enc_n <= enc_n + int'(core_enc_start);
      dec_n <= dec_n + int'(core_dec_start);
      if (!running && (core_enc_start || core_dec_start)) begin
        running <= 1'b1;
        t <= 0;
        is_dec <= core_dec_start;
        s_key <= h_key;
        s_nonce <= h_nonce;
        s_ad <= h_ad;
        s_text <= h_text;
        s_tag <= h_tag;
      end else if (running) t <= t + 1;
    end
  end

  // the opposite done line is pulsed early as noise; results stream out GAP_CYC+1 cycles after an honoured done
  assign core_enc_done = running && (is_dec ? t < 8 : t == m_dd);
  assign core_dec_done = running && (is_dec ? t == m_dd : t < 8);
  assign core_auth = running && m_auth && t == m_dd;
  always_comb begin
    kk = t - (m_dd < START_CYC ? START_CYC : m_dd) - 1 - GAP_CYC;
    so_en = running && m_dd >= 0 && kk >= 0 && kk < MAX;
    core_text_SO = so_en ? m_text[kk[6:0]] : 1'b0;
    core_tag_SO = so_en ? m_tag[kk[6:0]] : 1'b0;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_req(input bit mode, input logic [127:0] key, input logic [127:0] nonce,
                         input logic [A_L-1:0] ad, input logic [127:0] text, input logic [127:0] tag,
                         input int dd, input bit auth, input logic [127:0] otext,
                         input logic [127:0] otag, input int hold);
    bit tmo, ok;
    int e, n, exp_n;
    logic [127:0] g_text, g_tag;
    logic [2:0] g_flags;
    tmo = dd < 0 || dd >= START_CYC + TIMEOUT;
    e = dd < START_CYC ? START_CYC : dd;
    exp_n = tmo ? MAX + 1 + START_CYC + TIMEOUT : 2 * MAX + e + 2 + GAP_CYC;
    m_dd = dd;
    m_auth = auth;
    m_text = otext;
    m_tag = otag;
    @(negedge clk);
    req_mode = mode;
    req_key = key;
    req_nonce = nonce;
    req_ad = ad;
    req_text = text;
    req_tag = tag;
    req_valid = 1'b1;
    chk("req_ready", req_ready, 1);
    n = 0;
    ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!rsp_valid) begin
        ok &= busy && !req_ready;
        req_valid = 1'($urandom_range(0, 1));
        req_key = rnd();
        req_text = rnd();
        req_mode = 1'($urandom);
      end
    end while (!rsp_valid && n < 6000);
    req_valid = 1'b0;
    chk("latency", n, exp_n);
    chk("busy_ignore", ok, 1);
    chk("rsp_err", rsp_err, tmo);
    chk("rsp_auth", rsp_auth, !tmo && mode && auth);
    chk("rsp_mode", rsp_mode, mode);
    chk("rsp_text", rsp_text, tmo ? 128'h0 : otext);
    chk("rsp_tag", rsp_tag, tmo ? 128'h0 : otag);
    chk("key_in", s_key, key);
    chk("nonce_in", s_nonce, nonce);
    chk("ad_in", s_ad, {ad, {(MAX - A_L){1'b0}}});
    chk("text_in", s_text, text);
    chk("tag_in", s_tag, tag);
    chk("enc_start_n", enc_n, mode ? 0 : START_CYC);
    chk("dec_start_n", dec_n, mode ? START_CYC : 0);
    g_text = rsp_text;
    g_tag = rsp_tag;
    g_flags = {rsp_err, rsp_auth, rsp_mode};
    ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      ok &= rsp_valid && !req_ready && rsp_text == g_text && rsp_tag == g_tag &&
            {rsp_err, rsp_auth, rsp_mode} == g_flags;
    end
    if (hold > 0) chk("hold_stable", ok, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", {rsp_valid, req_ready, busy}, 3'b010);
  endtask

  initial begin
    logic [127:0] seq16;
    logic [A_L-1:0] seq14;
    seq16 = 128'h000102030405060708090a0b0c0d0e0f;
    seq14 = 112'h000102030405060708090a0b0c0d;
    repeat (3) @(negedge clk);
    chk("rst_ready", {req_ready, busy, rsp_valid}, 3'b100);
    chk("rst_rsp", {rsp_err, rsp_auth, rsp_mode, core_enc_start, core_dec_start}, 0);
    chk("rst_text", rsp_text | rsp_tag, 0);
    rst = 1'b0;
    run_req(1'b0, seq16, seq16, seq14, seq16, rnd(), 20, 1'b1,
            {16{8'hA5}}, 128'h0F21BF517921F2BBCE3C3F02A6EE18DA, 0);
    run_req(1'b1, seq16, seq16, seq14, rnd(), 128'h526E4B15B4B3184A2FC1F7D160E4E972, 20, 1'b1,
            rnd(), rnd(), 10);
    run_req(1'b0, rnd(), rnd(), rnd(), rnd(), rnd(), -1, 1'b0, rnd(), rnd(), 2);
    run_req(1'b0, rnd(), rnd(), rnd(), rnd(), rnd(), 30, 1'b0, rnd(), rnd(), 1);
    run_req(1'b1, rnd(), rnd(), rnd(), rnd(), rnd(), 2, 1'b1, rnd(), rnd(), 0);
    run_req(1'b1, rnd(), rnd(), rnd(), rnd(), rnd(), START_CYC + TIMEOUT - 1, 1'b1, rnd(), rnd(), 0);
    @(negedge clk);
    req_mode = 1'b0;
    req_key = '1;
    req_text = '1;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("load_bits", {core_key_SI, core_text_SI, busy}, 3'b111);
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", {core_key_SI, core_nonce_SI, core_ad_SI, core_text_SI, core_tag_SI,
                         core_enc_start, core_dec_start, rsp_valid, busy, rsp_err}, 0);
    chk("rst_mid_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release", {req_ready, busy, rsp_valid}, 3'b100);
    for (int r = 0; r < 6; r++)
      run_req(1'($urandom), rnd(), rnd(), rnd(), rnd(), rnd(), int'($urandom_range(0, 60)),
              1'($urandom), rnd(), rnd(), int'($urandom_range(0, 3)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ascon_ctrl.md
# ascon_ctrl

Host-side sequencer for the bit-serial `ascon` AEAD core. It accepts one parallel encrypt or decrypt request from a host. It shifts key, nonce, associated data, text and tag into the core one bit per clock, then pulses the core's start, waits for the core's ready, and deserialises text and tag back out. It returns a single parallel response, so the serial load/unload protocol is no longer hand-driven by test code.

## Interface
Parameters:
- `K`, 128, key width (bits).
- `A_L`, 112, associated-data width.
- `TEXT_L`, 128, plaintext/ciphertext width.
- `MAX`, max(`K`,`A_L`,`TEXT_L`,128), serial frame length in cycles.
- `START_CYC`, 5, cycles start strobe is held high.
- `GAP_CYC`, 2, cycles between core ready and first unload sample.
- `TIMEOUT`, 4095, max WAIT cycles before error.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_mode` in 1: 0 = encrypt, 1 = decrypt.
- `req_key` in `K`, `req_nonce` in 128, `req_ad` in `A_L`, `req_text` in `TEXT_L`, `req_tag` in 128: request operands.
- `core_key_SI`, `core_nonce_SI`, `core_ad_SI`, `core_text_SI`, `core_tag_SI` out 1 each: serial operands to the core.
- `core_enc_start`, `core_dec_start` out 1: core start strobes.
- `core_text_SO`, `core_tag_SO` in 1: serial results from the core.
- `core_enc_done`, `core_dec_done`, `core_auth` in 1: core status.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_text` out `TEXT_L`, `rsp_tag` out 128, `rsp_auth` out 1, `rsp_err` out 1, `rsp_mode` out 1: response fields.
- `busy` out 1: high in every state except IDLE.

## Operation
States: IDLE, LOAD, START, WAIT, GAP, UNLOAD, RESP.

- **IDLE**
  - `req_ready`=1.
  - On `req_valid & req_ready`, latch all operands and mode, clear the bit counter, go to LOAD.
- **LOAD** (`MAX` cycles)
  - On cycle i (0..`MAX`-1), drive `core_key_SI`=key[K-1-i], `core_nonce_SI`=nonce[127-i], `core_ad_SI`=ad[A_L-1-i], `core_text_SI`=text[TEXT_L-1-i], `core_tag_SI`=tag[127-i].
  - Any index <0 drives 0.
  - After i=`MAX`-1, go to START.
- **START** (`START_CYC` cycles)
  - Assert `core_enc_start` (mode 0) or `core_dec_start` (mode 1); the other strobe stays 0.
  - Serial inputs drive 0.
  - Go to WAIT.
- **WAIT**
  - Watch the done line matching the mode only. The done line is also watched during START; a done seen there is latched and honoured on WAIT entry.
  - On done: capture `core_auth` into `rsp_auth` (decrypt; forced 0 for encrypt), go to GAP.
  - The wait counter saturates. On reaching `TIMEOUT`: `rsp_err`=1, `rsp_text`/`rsp_tag`=0, go to RESP.
- **GAP**: hold for `GAP_CYC` cycles, then go to UNLOAD.
- **UNLOAD** (`MAX` cycles)
  - On cycle i, sample `core_text_SO` into rsp_text[i] (i<`TEXT_L`) and `core_tag_SO` into rsp_tag[i] (i<128).
  - Samples beyond those widths are discarded.
  - Go to RESP.
- **RESP**
  - `rsp_valid`=1 and all response fields stable until `rsp_valid & rsp_ready`, then go to IDLE.
  - `rsp_err` is cleared at the next request accept.

## Timing
- Reset (async): state IDLE; every output 0 except `req_ready`=1. Response registers and counters are cleared.
- Reset mid-operation aborts immediately. Strobes and serial outputs drop asynchronously, and no response is issued.
- Accept-to-first-load-bit: 1 cycle (the LOAD i=0 value appears the cycle after acceptance).
- Fixed overhead per request:
  - 1 accept cycle.
  - `MAX` load cycles.
  - `START_CYC` start cycles.
  - ≥1 WAIT cycle.
  - `GAP_CYC` gap cycles.
  - `MAX` unload cycles.
  - ≥1 RESP cycle.
- `req_ready` is combinational from state (IDLE only). There is no back-to-back accept in the same cycle as `rsp_valid` handshake completion; the next accept is the following cycle.
- `req_valid` seen while busy is ignored, with no buffering.
- Done asserted on the cycle the wait counter hits `TIMEOUT`: done wins and `rsp_err`=0.
- All core-facing outputs are registered.

## Structure
- Package `ascon_pkg` holds:
  - the state enum,
  - mode constants `MODE_ENC`/`MODE_DEC`,
  - a `max4` function for `MAX`,
  - default widths 128/112/128.
- One sub-module, `ascon_serdes`: parameterised PISO+SIPO shift register with load, shift-enable and index. It is instantiated once per operand lane, with one instance for text and one for tag.

## Test plan
- **Encrypt load order:** key=nonce=000102…0E0F, ad=000102…0c0d, text=000102…0e0f, behavioural core model records serial bits.
  - Model reconstructs exact operands.
  - `core_enc_start` is high for exactly 5 cycles.
  - `core_dec_start` stays 0.
- **Encrypt unload:** model raises done 20 cycles after start, then shifts text=A5A5…A5, tag=0F21BF517921F2BBCE3C3F02A6EE18DA.
  - Response carries those bit-for-bit.
  - `rsp_auth`=0, `rsp_err`=0.
- **Decrypt:** mode=1, tag=526E4B15B4B3184A2FC1F7D160E4E972, model asserts `core_auth`=1 with done.
  - `rsp_auth`=1, `rsp_mode`=1.
  - Only `core_dec_start` pulses.
- **Timeout:** model never asserts done.
  - After 4095 WAIT cycles: `rsp_valid`=1, `rsp_err`=1, text/tag=0.
  - The next request then succeeds with `rsp_err`=0.
- **Backpressure/reset:**
  - Hold `rsp_ready`=0 for 10 cycles: fields stay stable and `req_ready` stays 0.
  - Assert `rst` mid-LOAD: all outputs 0 the same cycle, and IDLE with `req_ready`=1 after release.
